// File: rtl/collision_arbiter.sv
// Per-frame collision arbiter: accumulates sprite overlaps between frame ticks,
// publishes them as per-object flags, and runs the score / lives / game-over state.
module collision_arbiter #(
  parameter int          NE         = 4,
  parameter int          NPE        = 2,
  parameter int          NPP        = 4,
  parameter int          INV_FRAMES = 60,
  parameter logic [15:0] KILL_PTS   = 16'd100
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic                Start,
  input  logic [NE-1:0]       EShipOn,
  input  logic [NE*NPE-1:0]   EProjOn,
  input  logic                PShipOn,
  input  logic [NPP-1:0]      PProjOn,
  output logic [NE-1:0]       EShipColl,
  output logic [NE*NPE-1:0]   EProjColl,
  output logic [NPP-1:0]      PProjColl,
  output logic                PShipHit,
  output logic [15:0]         Score,
  output logic [1:0]          Lives,
  output logic                GameOver
);

  localparam int CW = $clog2(INV_FRAMES + 1);
  localparam int KW = $clog2(NE + 1);

  typedef enum logic [1:0] {PLAY, HIT, OVER} state_t;

  state_t              state;
  logic [CW-1:0]       inv_cnt;
  logic                fc_meta, fc_sync, fc_prev;
  logic                tick, vulnerable;
  logic [NE-1:0]       acc_eship, new_eship;
  logic [NE*NPE-1:0]   acc_eproj, new_eproj;
  logic [NPP-1:0]      acc_pproj, new_pproj;
  logic                acc_phit, new_phit;
  logic [KW-1:0]       kills;
  logic [31:0]         score_sum;
  logic [15:0]         score_next;

  // Flops come out of reset high so a frame_clk already high at release is not a rising edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fc_meta <= 1'b1;
      fc_sync <= 1'b1;
      fc_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking, so each stage samples the previous stage's old value.
      fc_meta <= frame_clk;
      fc_sync <= fc_meta;
      fc_prev <= fc_sync;
    end
  end

  assign tick       = fc_sync & ~fc_prev;
  assign vulnerable = (state == PLAY);

  assign new_eship = EShipOn & {NE{(|PProjOn) | (PShipOn & vulnerable)}};
  assign new_pproj = PProjOn & {NPP{|EShipOn}};
  assign new_eproj = EProjOn & {(NE*NPE){PShipOn & vulnerable}};
  assign new_phit  = vulnerable & PShipOn & ((|EProjOn) | (|EShipOn));

  always_comb begin
    // NOTE: default before the loop so every path assigns kills and no latch is inferred.
    kills = '0;
    for (int i = 0; i < NE; i++) kills = kills + KW'(acc_eship[i]);
  end

  assign score_sum  = 32'(Score) + 32'(KILL_PTS) * 32'(kills);
  assign score_next = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= PLAY;
      inv_cnt   <= '0;
      Score     <= '0;
      Lives     <= 2'd3;
      GameOver  <= 1'b0;
      acc_eship <= '0;
      acc_eproj <= '0;
      acc_pproj <= '0;
      acc_phit  <= 1'b0;
      EShipColl <= '0;
      EProjColl <= '0;
      PProjColl <= '0;
      PShipHit  <= 1'b0;
    end else if (state == OVER && Start) begin
      // Restart beats a coincident tick: nothing from the dying frame is scored or shown.
      state     <= PLAY;
      inv_cnt   <= '0;
      Score     <= '0;
      Lives     <= 2'd3;
      GameOver  <= 1'b0;
      acc_eship <= '0;
      acc_eproj <= '0;
      acc_pproj <= '0;
      acc_phit  <= 1'b0;
      EShipColl <= '0;
      EProjColl <= '0;
      PProjColl <= '0;
      PShipHit  <= 1'b0;
    end else if (tick) begin
      EShipColl <= acc_eship;
      EProjColl <= acc_eproj;
      PProjColl <= acc_pproj;
      PShipHit  <= acc_phit;
      acc_eship <= new_eship;
      acc_eproj <= new_eproj;
      acc_pproj <= new_pproj;
      acc_phit  <= new_phit;
      case (state)
        PLAY: begin
          Score <= score_next;
          if (acc_phit) begin
            if (Lives > 2'd1) begin
              Lives   <= Lives - 2'd1;
              inv_cnt <= CW'(INV_FRAMES);
              state   <= HIT;
            end else begin
              Lives    <= 2'd0;
              state    <= OVER;
              GameOver <= 1'b1;
            end
          end
        end
        HIT: begin
          Score   <= score_next;
          inv_cnt <= inv_cnt - CW'(1);
          if (inv_cnt == CW'(1)) state <= PLAY;
        end
        default: ;
      endcase
    end else begin
      acc_eship <= acc_eship | new_eship;
      acc_eproj <= acc_eproj | new_eproj;
      acc_pproj <= acc_pproj | new_pproj;
      acc_phit  <= acc_phit  | new_phit;
    end
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench for collision_arbiter: a frame-level game model queues expected
// outputs with their due cycle; an independent monitor compares when each comes due.
module tb_collision_arbiter;

  localparam int NE   = 4;
  localparam int NPE  = 2;
  localparam int NPP  = 4;
  localparam int INV  = 60;
  localparam int KILL = 100;
  localparam int L    = 8;   // clock cycles per frame; cycle 0 is the tick cycle

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_clk;
  logic              start;
  logic [NE-1:0]     EShipOn;
  logic [NE*NPE-1:0] EProjOn;
  logic              PShipOn;
  logic [NPP-1:0]    PProjOn;
  logic [NE-1:0]     EShipColl;
  logic [NE*NPE-1:0] EProjColl;
  logic [NPP-1:0]    PProjColl;
  logic              PShipHit;
  logic [15:0]       Score;
  logic [1:0]        Lives;
  logic              GameOver;

  collision_arbiter dut (
    .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .Start(start),
    .EShipOn(EShipOn), .EProjOn(EProjOn), .PShipOn(PShipOn), .PProjOn(PProjOn),
    .EShipColl(EShipColl), .EProjColl(EProjColl), .PProjColl(PProjColl),
    .PShipHit(PShipHit), .Score(Score), .Lives(Lives), .GameOver(GameOver)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                due;
    logic [NE-1:0]     es;
    logic [NE*NPE-1:0] ep;
    logic [NPP-1:0]    pp;
    logic              ph;
    int                score;
    int                lives;
    logic              over;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Game model: frame-level state, accumulated overlaps and currently shown flags
  int                m_score, m_lives, m_inv;
  bit                m_over;
  logic [NE-1:0]     a_es, o_es;
  logic [NE*NPE-1:0] a_ep, o_ep;
  logic [NPP-1:0]    a_pp, o_pp;
  logic              a_ph, o_ph;

  function automatic bit vuln();
    return !m_over && m_inv == 0;
  endfunction

  task automatic model_reset();
    m_score = 0; m_lives = 3; m_inv = 0; m_over = 0;
    a_es = '0; a_ep = '0; a_pp = '0; a_ph = 1'b0;
    o_es = '0; o_ep = '0; o_pp = '0; o_ph = 1'b0;
  endtask

  task automatic push(input int due);
    exp_t e;
    e.due = due; e.es = o_es; e.ep = o_ep; e.pp = o_pp; e.ph = o_ph;
    e.score = m_score; e.lives = m_lives; e.over = m_over;
    q.push_back(e);
  endtask

  task automatic model_tick(input bit restart, input int due);
    int gain;
    if (restart) begin
      model_reset();
    end else begin
      o_es = a_es; o_ep = a_ep; o_pp = a_pp; o_ph = a_ph;
      gain = KILL * $countones(a_es);
      if (!m_over) m_score = (m_score + gain > 65535) ? 65535 : m_score + gain;
      if (m_inv > 0) m_inv--;
      else if (!m_over && a_ph) begin
        if (m_lives > 1) begin m_lives--; m_inv = INV; end
        else begin m_lives = 0; m_over = 1; end
      end
      a_es = '0; a_ep = '0; a_pp = '0; a_ph = 1'b0;
    end
    push(due);
  endtask

  // Frame stimulus table
  logic [NE-1:0]     f_es[L];
  logic [NE*NPE-1:0] f_ep[L];
  logic              f_ps[L];
  logic [NPP-1:0]    f_pp[L];
  int                f_start, f_rst, f_mid;

  task automatic clear_frame();
    for (int c = 0; c < L; c++) begin
      f_es[c] = '0; f_ep[c] = '0; f_ps[c] = 1'b0; f_pp[c] = '0;
    end
    f_start = -1; f_rst = -1; f_mid = -1;
  endtask

  task automatic set_cov(input int c, input logic [NE-1:0] es, input logic [NE*NPE-1:0] ep,
                         input logic ps, input logic [NPP-1:0] pp);
    f_es[c] = es; f_ep[c] = ep; f_ps[c] = ps; f_pp[c] = pp;
  endtask

  // A ship dies to any player shot or a vulnerable player ship; a vulnerable player
  // is hit by any enemy object it overlaps.
  task automatic accumulate(input int c, input bit v);
    a_es |= f_es[c] & {NE{(|f_pp[c]) | (f_ps[c] & v)}};
    a_pp |= f_pp[c] & {NPP{|f_es[c]}};
    a_ep |= f_ep[c] & {(NE*NPE){f_ps[c] & v}};
    a_ph |= v & f_ps[c] & ((|f_ep[c]) | (|f_es[c]));
  endtask

  task automatic run_frame(input bit tick_c0);
    bit pv, discard;
    int due;
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      due   = cyc + 1;
      rst_n = !(f_rst >= 0 && c >= f_rst);
      if (c == L - 2) frame_clk = 1'b1;
      else if (c == 3) frame_clk = 1'b0;
      start   = (f_start == c);
      EShipOn = f_es[c]; EProjOn = f_ep[c]; PShipOn = f_ps[c]; PProjOn = f_pp[c];
      discard = 0;
      pv      = vuln();
      if (c == 0 && tick_c0) begin
        discard = start && m_over;
        model_tick(start && m_over, due);
      end else if (rst_n && start && m_over) begin
        model_reset();
        push(due);
        discard = 1;
      end
      if (!rst_n) begin
        discard = 1;
        if (c == f_rst) begin model_reset(); push(due); end
      end
      if (!discard) accumulate(c, (c == 0 && tick_c0) ? pv : vuln());
      if (c == f_mid) push(due);
      @(posedge clk);
    end
  endtask

  task automatic deplete();
    int guard = 0;
    while (!m_over && guard < 400) begin
      clear_frame();
      if (vuln()) set_cov(5, 4'b0001, 8'b0100_0000, 1'b1, 4'b0000);
      run_frame(1);
      guard++;
    end
    check("reached_game_over", 32'(m_over), 32'd1);
  endtask

  // Monitor: compares DUT outputs against each queued expectation on its due cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("due_cycle", cyc, e.due);
        check("EShipColl", 32'(EShipColl), 32'(e.es));
        check("EProjColl", 32'(EProjColl), 32'(e.ep));
        check("PProjColl", 32'(PProjColl), 32'(e.pp));
        check("PShipHit", 32'(PShipHit), 32'(e.ph));
        check("Score", 32'(Score), e.score);
        check("Lives", 32'(Lives), e.lives);
        check("GameOver", 32'(GameOver), 32'(e.over));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int plan;
    rst_n = 1'b1; frame_clk = 1'b0; start = 1'b0;
    EShipOn = '0; EProjOn = '0; PShipOn = 1'b0; PProjOn = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    push(cyc + 1);
    @(posedge clk);

    // Single kill accumulated over three mid-frame cycles, then a quiet frame
    clear_frame(); run_frame(0);
    clear_frame();
    for (int c = 2; c <= 4; c++) set_cov(c, 4'b0010, '0, 1'b0, 4'b0001);
    run_frame(1);
    clear_frame(); run_frame(1);
    clear_frame(); run_frame(1);

    // Overlap only in the tick cycle belongs to the next frame
    clear_frame(); set_cov(0, 4'b0100, '0, 1'b0, 4'b0010); run_frame(1);
    clear_frame(); run_frame(1);

    // Player hit, then repeated overlaps throughout the invulnerability window
    clear_frame(); set_cov(4, '0, 8'b0000_1000, 1'b1, '0); run_frame(1);
    for (int i = 0; i < INV; i++) begin
      clear_frame(); set_cov(3, '0, 8'b0000_1000, 1'b1, '0); run_frame(1);
    end
    clear_frame(); run_frame(1);

    // Randomized play with occasional Start pulses
    for (int i = 0; i < 120; i++) begin
      clear_frame();
      for (int c = 0; c < L; c++) begin
        if ($urandom_range(0, 2) == 0) f_es[c] = NE'($urandom);
        if ($urandom_range(0, 3) == 0) f_ep[c] = (NE*NPE)'($urandom);
        if ($urandom_range(0, 4) == 0) f_ps[c] = 1'b1;
        if ($urandom_range(0, 2) == 0) f_pp[c] = NPP'($urandom);
      end
      if ($urandom_range(0, 7) == 0) f_start = $urandom_range(0, L - 1);
      run_frame(1);
    end

    // Lose every life, keep reporting in OVER, restart on a tick, lose 3 lives again
    deplete();
    clear_frame(); set_cov(2, 4'b0011, 8'b0000_0001, 1'b1, 4'b0001); run_frame(1);
    clear_frame(); set_cov(3, 4'b0100, '0, 1'b0, 4'b0100); run_frame(1);
    clear_frame(); f_start = 0; set_cov(0, 4'b1000, '0, 1'b0, 4'b0001); run_frame(1);
    clear_frame(); run_frame(1);
    deplete();
    clear_frame(); f_start = 4; set_cov(2, 4'b0001, '0, 1'b0, 4'b0001); run_frame(1);
    clear_frame(); run_frame(1);

    // Reset mid-frame with frame_clk high through release
    clear_frame();
    for (int c = 1; c <= 2; c++) set_cov(c, 4'b1000, '0, 1'b0, 4'b1000);
    f_rst = 6;
    run_frame(1);
    clear_frame();
    set_cov(0, 4'b0001, '0, 1'b0, 4'b0001);
    set_cov(1, 4'b0001, '0, 1'b0, 4'b0001);
    f_mid = 2;
    run_frame(0);
    clear_frame(); run_frame(1);

    // Drive the score up to 65500, then over the top
    plan = m_score + KILL * $countones(a_es);
    while (plan + 4 * KILL <= 65500) begin
      clear_frame(); set_cov(2, 4'b1111, '0, 1'b0, 4'b0001); run_frame(1);
      plan += 4 * KILL;
    end
    while (plan + KILL <= 65500) begin
      clear_frame(); set_cov(2, 4'b0100, '0, 1'b0, 4'b0001); run_frame(1);
      plan += KILL;
    end
    clear_frame(); set_cov(2, 4'b0011, '0, 1'b0, 4'b0001); run_frame(1);
    clear_frame(); set_cov(2, 4'b1000, '0, 1'b0, 4'b0001); run_frame(1);
    clear_frame(); run_frame(1);
    check("score_saturated", 32'(m_score), 32'hFFFF);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
